// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// abs_tc works on a sign/zero-extended MUL_MAX_WIDTH value so any operand width up to that limit can use it.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mul_state_e;

    localparam int DEF_MUL_WIDTH = 32;
    localparam int MUL_MAX_WIDTH = 128;

    // Caller extends the operand (sign-extend when signed) before the call; truncate the result back to width.
    function automatic logic [MUL_MAX_WIDTH-1:0] abs_tc(
        input logic [MUL_MAX_WIDTH-1:0] value,
        input logic                     is_signed
    );
        return (is_signed && value[MUL_MAX_WIDTH-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/seq_mul_param.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, signed or unsigned per operation.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy (no queueing).
module seq_mul_param
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_e         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [CW-1:0]      r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [MUL_MAX_WIDTH-1:0] w_a_ext;
    logic [MUL_MAX_WIDTH-1:0] w_b_ext;
    logic [WIDTH-1:0]         w_a_mag;
    logic [WIDTH-1:0]         w_b_mag;
    logic [WIDTH:0]           w_addend;
    logic [WIDTH:0]           w_sum;
    logic [2*WIDTH-1:0]       w_result;

    always_comb begin
        w_a_ext = {MUL_MAX_WIDTH{is_signed & a[WIDTH-1]}};
        w_b_ext = {MUL_MAX_WIDTH{is_signed & b[WIDTH-1]}};
        w_a_ext[WIDTH-1:0] = a;
        w_b_ext[WIDTH-1:0] = b;
    end

    // Signed min magnitude 2^(WIDTH-1) still fits in WIDTH unsigned bits, so truncation is lossless.
    assign w_a_mag = WIDTH'(abs_tc(w_a_ext, is_signed));
    assign w_b_mag = WIDTH'(abs_tc(w_b_ext, is_signed));

    assign w_addend = r_mplier[0] ? {1'b0, r_mcand} : '0;
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_result = r_neg ? -r_acc : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    // The carry bit of the sum drops into the top of the shifted accumulator.
                    r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    {r_hi, r_lo} <= w_result;
                    r_done       <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_seq_mul_param.sv
// Directed bench: vector table at WIDTH=32, start-ignore/reset sequences, and exhaustive WIDTH=4 against a `*` model.
module tb_seq_mul_param;
    import mul_pkg::*;

    logic clk;
    logic rst_n;

    logic        s32_start, s32_sgn, s32_busy, s32_done;
    logic [31:0] s32_a, s32_b, s32_hi, s32_lo;
    logic        s4_start, s4_sgn, s4_busy, s4_done;
    logic [3:0]  s4_a, s4_b, s4_hi, s4_lo;

    int n_cmp = 0;
    int n_err = 0;

    seq_mul_param #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(s32_start), .is_signed(s32_sgn),
        .a(s32_a), .b(s32_b), .busy(s32_busy), .done(s32_done), .hi(s32_hi), .lo(s32_lo)
    );

    seq_mul_param #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .is_signed(s4_sgn),
        .a(s4_a), .b(s4_b), .busy(s4_busy), .done(s4_done), .hi(s4_hi), .lo(s4_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output int bc);
        s32_a = a; s32_b = b; s32_sgn = s; s32_start = 1'b1;
        @(negedge clk);
        s32_start = 1'b0;
        s32_a = ~a; s32_b = b + 32'd1; s32_sgn = ~s;
        lat = 0; bc = 0;
        while (!s32_done && lat < 200) begin
            if (s32_busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s, output int lat);
        s4_a = a; s4_b = b; s4_sgn = s; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        s4_a = ~a; s4_b = ~b; s4_sgn = ~s;
        lat = 0;
        while (!s4_done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bc, seen;
        logic [MUL_MAX_WIDTH-1:0] v;

        vt[0] = '{32'd10,        32'd20,        1'b0, 32'h0000_0000, 32'h0000_00C8};
        vt[1] = '{32'hFFFF_FFFB, 32'd7,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
        vt[2] = '{32'hFFFF_FFFB, 32'd7,         1'b0, 32'h0000_0006, 32'hFFFF_FFDD};
        vt[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        vt[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
        vt[5] = '{32'h8000_0000, 32'd1,         1'b1, 32'hFFFF_FFFF, 32'h8000_0000};
        vt[6] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vt[7] = '{32'h1234_5678, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vt[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
        vt[9] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h3FFF_FFFF, 32'h0000_0001};

        rst_n = 1'b0;
        s32_start = 1'b0; s32_sgn = 1'b0; s32_a = '0; s32_b = '0;
        s4_start = 1'b0;  s4_sgn = 1'b0;  s4_a = '0;  s4_b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(s32_busy), 64'd0);
        check("rst_done", 64'(s32_done), 64'd0);
        check("rst_hi", 64'(s32_hi), 64'd0);
        check("rst_lo", 64'(s32_lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        v = '1; v[31:0] = 32'hFFFF_FFFB;
        check("abs_tc_signed", 64'(abs_tc(v, 1'b1)), 64'd5);
        v = '0; v[31:0] = 32'hFFFF_FFFB;
        check("abs_tc_unsigned", 64'(abs_tc(v, 1'b0)), 64'hFFFF_FFFB);

        // Vectors run back to back: each start lands in the cycle done of the previous op is high.
        for (int i = 0; i < 10; i++) begin
            run32(vt[i].a, vt[i].b, vt[i].sgn, lat, bc);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
            check($sformatf("vec%0d_hi", i), 64'(s32_hi), 64'(vt[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(s32_lo), 64'(vt[i].lo));
        end

        @(negedge clk);
        check("done_one_cycle", 64'(s32_done), 64'd0);
        check("hold_hi", 64'(s32_hi), 64'h3FFF_FFFF);

        // 3*15, with a second start (16*7) pulsed 5 cycles into the run.
        s32_a = 32'd3; s32_b = 32'd15; s32_sgn = 1'b0; s32_start = 1'b1;
        @(negedge clk);
        s32_start = 1'b0;
        check("start_keeps_lo", 64'(s32_lo), 64'd1);
        lat = 0;
        while (!s32_done && lat < 200) begin
            if (lat == 5) begin
                s32_a = 32'd16; s32_b = 32'd7; s32_start = 1'b1;
            end else begin
                s32_start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        s32_start = 1'b0;
        check("ignore_latency", 64'(lat), 64'd33);
        check("ignore_hi", 64'(s32_hi), 64'd0);
        check("ignore_lo", 64'(s32_lo), 64'd45);

        // 10*19 started in the done cycle, then reset mid-flight.
        s32_a = 32'd10; s32_b = 32'd19; s32_start = 1'b1;
        @(negedge clk);
        s32_start = 1'b0;
        repeat (9) @(negedge clk);
        check("b2b_busy", 64'(s32_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(s32_busy), 64'd0);
        check("arst_done", 64'(s32_done), 64'd0);
        check("arst_hi", 64'(s32_hi), 64'd0);
        check("arst_lo", 64'(s32_lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (s32_done || s32_busy) seen = 1;
        end
        check("no_done_after_reset", 64'(seen), 64'd0);

        // Exhaustive WIDTH=4 in both modes against the behavioural product.
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    int ia, ib, p;
                    logic [7:0] e;
                    ia = (s == 1 && x >= 8) ? x - 16 : x;
                    ib = (s == 1 && y >= 8) ? y - 16 : y;
                    p  = ia * ib;
                    e  = 8'(p);
                    run4(4'(x), 4'(y), s[0], lat);
                    check($sformatf("w4_lat s=%0d a=%0d b=%0d", s, x, y), 64'(lat), 64'd5);
                    check($sformatf("w4_prod s=%0d a=%0d b=%0d", s, x, y), 64'({s4_hi, s4_lo}), 64'(e));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
